// File: rtl/qmf_synth_coef_ctrl_if.sv
// Serial coefficient stream (valid/ready) into qmf_synth_coef_ctrl.
// master drives words, slave is the controller's shadow-bank loader.
interface qmf_synth_coef_ctrl_if #(
  parameter int COEFW = 16
) ();
  logic             valid;
  logic             ready;
  logic [COEFW-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/qmf_synth_coef_ctrl.sv
// Coefficient bank controller / sample sequencer for qmf_synthesis_core.
// Optional macro QMF_COEF_SYM_EN: load NTAPS/2 words and mirror them into a symmetric prototype.
module qmf_synth_coef_ctrl #(
  parameter int COEFW = 16,
  parameter int NTAPS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  qmf_synth_coef_ctrl_if.slave   s,
  input  logic                   sample_stb,
  output logic                   core_en,
  output logic [NTAPS*COEFW-1:0] coef_flat,
  output logic                   bank_valid,
  output logic                   settled,
  output logic                   swap_done,
  output logic                   load_err
);

`ifdef QMF_COEF_SYM_EN
  localparam int NW = NTAPS / 2;
`else
  localparam int NW = NTAPS;
`endif
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {EMPTY, SETTLE, RUN} state_t;

  state_t                 state_reg;
  logic [IW-1:0]          wr_idx_reg;
  logic                   shadow_full_reg;
  logic [COEFW-1:0]       shadow_reg [NTAPS];
  logic [NTAPS*COEFW-1:0] shadow_flat;
  logic [NTAPS*COEFW-1:0] active_reg;
  logic [SW-1:0]          settle_cnt_reg;
  logic                   load_err_reg;
  logic                   swap_done_reg;
  logic                   bank_valid_reg;
  logic                   settled_reg;
  logic                   accept;
  logic                   at_end;
  logic                   swap;

  assign s.ready = !shadow_full_reg;
  assign accept  = s.valid && !shadow_full_reg;
  assign at_end  = (wr_idx_reg == IW'(NW - 1));
  assign swap    = shadow_full_reg && ((state_reg == EMPTY) || sample_stb);

  // Each shadow slice listens to one stream index; in symmetric mode the
  // upper half mirrors the lower half.
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_shadow
      localparam int SRC = (gi < NW) ? gi : (NTAPS - 1 - gi);
      always_ff @(posedge clk) begin
        if (accept && (wr_idx_reg == IW'(SRC))) begin
          shadow_reg[gi] <= s.data;
        end
      end
      assign shadow_flat[gi*COEFW +: COEFW] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg      <= '0;
      shadow_full_reg <= 1'b0;
      load_err_reg    <= 1'b0;
    end else begin
      load_err_reg <= 1'b0;
      if (swap) begin
        shadow_full_reg <= 1'b0;
      end
      // accept and swap are mutually exclusive: accept needs an empty shadow
      if (accept) begin
        if (at_end && s.last) begin
          shadow_full_reg <= 1'b1;
          wr_idx_reg      <= '0;
        end else if (at_end || s.last) begin
          load_err_reg <= 1'b1;
          wr_idx_reg   <= '0;
        end else begin
          wr_idx_reg <= wr_idx_reg + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= EMPTY;
      active_reg     <= '0;
      settle_cnt_reg <= '0;
      swap_done_reg  <= 1'b0;
      bank_valid_reg <= 1'b0;
      settled_reg    <= 1'b0;
    end else begin
      swap_done_reg <= swap;
      // A swap restarts the settle window even if a decrement is due this cycle
      if (swap) begin
        active_reg     <= shadow_flat;
        settle_cnt_reg <= SW'(NTAPS);
        state_reg      <= SETTLE;
        bank_valid_reg <= 1'b1;
        settled_reg    <= 1'b0;
      end else if ((state_reg == SETTLE) && sample_stb) begin
        if (settle_cnt_reg == SW'(1)) begin
          state_reg   <= RUN;
          settled_reg <= 1'b1;
        end else begin
          settle_cnt_reg <= settle_cnt_reg - SW'(1);
        end
      end
    end
  end

  assign core_en    = sample_stb && (state_reg != EMPTY);
  assign coef_flat  = active_reg;
  assign bank_valid = bank_valid_reg;
  assign settled    = settled_reg;
  assign swap_done  = swap_done_reg;
  assign load_err   = load_err_reg;

endmodule
